// File: rtl/mips150_mem_unit_pkg.sv
// Shared encodings for the MIPS150 memory unit: load mask codes, MemWrite codes,
// FSM states and access-size helpers.
package mips150_mem_unit_pkg;

  localparam logic [2:0] MASK_LB  = 3'b000;
  localparam logic [2:0] MASK_LH  = 3'b001;
  localparam logic [2:0] MASK_LW  = 3'b010;
  localparam logic [2:0] MASK_LBU = 3'b011;
  localparam logic [2:0] MASK_LHU = 3'b100;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SB   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SW   = 2'b11;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;

  function automatic size_e load_size(input logic [2:0] m);
    case (m)
      MASK_LB, MASK_LBU: return SZ_BYTE;
      MASK_LH, MASK_LHU: return SZ_HALF;
      default:           return SZ_WORD;
    endcase
  endfunction

  function automatic size_e store_size(input logic [1:0] mw);
    case (mw)
      MW_SB:   return SZ_BYTE;
      MW_SH:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips150_load_extract.sv
// Combinational load extractor: picks the byte/half lane named by offset and
// sign- or zero-extends it according to the load mask.
module mips150_load_extract
  import mips150_mem_unit_pkg::*;
(
  input  logic [2:0]  mask,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[8*offset +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    case (mask)
      MASK_LB:  data = {{24{b[7]}}, b};
      MASK_LH:  data = {{16{h[15]}}, h};
      MASK_LBU: data = {24'd0, b};
      MASK_LHU: data = {16'd0, h};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mips150_mem_unit.sv
// MIPS150 memory-stage unit: byte-enable stores issued combinationally, loads
// waited on in a two-state FSM with timeout, misalignment and bus-error flags.
module mips150_mem_unit
  import mips150_mem_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        load,
  input  logic [2:0]  mask,
  input  logic [1:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_err,
  output logic [31:0] exc_addr
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state, state_nxt;
  logic [2:0]      mask_q;
  logic [1:0]      off_q;
  logic [31:0]     addr_q;
  logic [TO_W-1:0] cnt;

  logic        is_store, is_load, mis, fire;
  logic        acc_store, acc_load, flag_mis, got_data, timed_out;
  logic [31:0] ext;

  mips150_load_extract u_extract (
    .mask   (mask_q),
    .offset (off_q),
    .rdata  (mem_rdata),
    .data   (ext)
  );

  // A store takes priority over a simultaneous load; unknown masks never access.
  always_comb begin
    is_store  = mem_write != MW_NONE;
    is_load   = load && !is_store && (mask <= MASK_LHU);
    mis       = is_store ? is_misaligned(store_size(mem_write), addr[1:0])
                         : is_misaligned(load_size(mask), addr[1:0]);
    fire      = !rst && (state == ST_IDLE) && req_valid;
    acc_store = fire && is_store && !mis;
    acc_load  = fire && is_load && !mis;
    flag_mis  = fire && (is_store || is_load) && mis;
    got_data  = (state == ST_WAIT) && mem_rvalid;
    timed_out = (state == ST_WAIT) && !mem_rvalid && (cnt == TO_LAST);
  end

  always_comb begin
    state_nxt = state;
    req_ready = (state == ST_IDLE);
    stall     = (state == ST_WAIT);
    mem_en    = acc_store || acc_load;
    mem_we    = 4'b0000;
    mem_addr  = addr[31:2];
    case (mem_write)
      MW_SB:   mem_wdata = {4{wdata[7:0]}};
      MW_SH:   mem_wdata = {2{wdata[15:0]}};
      default: mem_wdata = wdata;
    endcase
    if (acc_store) begin
      case (mem_write)
        MW_SB:   mem_we = 4'b0001 << addr[1:0];
        MW_SH:   mem_we = addr[1] ? 4'b1100 : 4'b0011;
        default: mem_we = 4'b1111;
      endcase
    end
    case (state)
      ST_IDLE: if (acc_load) state_nxt = ST_WAIT;
      ST_WAIT: if (got_data || timed_out) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mask_q     <= MASK_LB;
      off_q      <= 2'b00;
      addr_q     <= 32'd0;
      cnt        <= '0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      exc_addr   <= 32'd0;
    end else begin
      state      <= state_nxt;
      load_valid <= got_data;
      misaligned <= flag_mis;
      bus_err    <= timed_out;
      if (acc_load) begin
        mask_q <= mask;
        off_q  <= addr[1:0];
        addr_q <= addr;
        cnt    <= '0;
      end else if (state == ST_WAIT && cnt != TO_LAST) begin
        cnt <= cnt + 1'b1;
      end
      if (got_data) load_data <= ext;
      if (flag_mis) exc_addr <= addr;
      else if (timed_out) exc_addr <= addr_q;
    end
  end

endmodule

// File: tb/tb_mips150_mem_unit.sv
// Directed and randomized bench for mips150_mem_unit against an arithmetic
// model of lane selection, byte enables and load latency.
module tb_mips150_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        load;
  logic [2:0]  mask;
  logic [1:0]  mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        bus_err;
  logic [31:0] exc_addr;

  int checks   = 0;
  int failures = 0;

  mips150_mem_unit #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .load(load), .mask(mask), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .load_data(load_data), .load_valid(load_valid), .misaligned(misaligned),
    .bus_err(bus_err), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int ld_bytes(input int m);
    case (m)
      0, 3:    return 1;
      1, 4:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int m, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) % 256;
    h = (rd >> (8 * (a % 4))) % 65536;
    case (m)
      0:       return (b >= 128) ? b - 32'd256 : b;
      1:       return (h >= 32768) ? h - 32'd65536 : h;
      3:       return b;
      4:       return h;
      default: return rd;
    endcase
  endfunction

  task automatic idle_inputs();
    req_valid = 0; load = 0; mask = 0; mem_write = 0; mem_rvalid = 0;
  endtask

  // Load with rvalid presented in the lat-th WAIT cycle.
  task automatic do_load(input string tag, input int m, input logic [31:0] a,
                         input logic [31:0] rd, input int lat);
    @(posedge clk); #1;
    req_valid = 1; load = 1; mask = 3'(m); mem_write = 0; addr = a; mem_rdata = $urandom;
    @(negedge clk);
    chk({tag, ".req_en"}, mem_en, 1);
    chk({tag, ".req_we"}, mem_we, 0);
    chk({tag, ".req_stall"}, stall, 0);
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      req_valid = 0; load = 0;
      mem_rvalid = (i == lat - 1);
      mem_rdata  = (i == lat - 1) ? rd : $urandom;
      @(negedge clk);
      chk({tag, ".wait_stall"}, stall, 1);
      chk({tag, ".wait_en"}, mem_en, 0);
    end
    @(posedge clk); #1;
    mem_rvalid = 0; mem_rdata = $urandom;
    @(negedge clk);
    chk({tag, ".valid"}, load_valid, 1);
    chk({tag, ".data"}, load_data, ref_load(m, a, rd));
    chk({tag, ".stall_drop"}, stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".valid_pulse"}, load_valid, 0);
  endtask

  task automatic do_store(input string tag, input int mw, input logic [31:0] a,
                          input logic [31:0] d, input logic ld);
    int nb;
    logic [3:0]  we;
    logic [31:0] wd;
    nb = 1 << (mw - 1);
    if (nb == 1) begin we = 4'b0001 << (a % 4); wd = (d % 256) * 32'h01010101; end
    else if (nb == 2) begin we = 4'b0011 << (a % 4); wd = (d % 65536) * 32'h00010001; end
    else begin we = 4'hF; wd = d; end
    @(posedge clk); #1;
    req_valid = 1; load = ld; mask = 3'($urandom_range(0, 4)); mem_write = 2'(mw);
    addr = a; wdata = d;
    @(negedge clk);
    chk({tag, ".en"}, mem_en, 1);
    chk({tag, ".we"}, mem_we, we);
    chk({tag, ".wdata"}, mem_wdata, wd);
    chk({tag, ".addr"}, {2'b00, mem_addr}, a >> 2);
    chk({tag, ".stall"}, stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1);
    chk({tag, ".no_mis"}, misaligned, 0);
  endtask

  task automatic do_mis(input string tag, input logic ld, input int m, input int mw,
                        input logic [31:0] a);
    @(posedge clk); #1;
    req_valid = 1; load = ld; mask = 3'(m); mem_write = 2'(mw); addr = a; wdata = $urandom;
    @(negedge clk);
    chk({tag, ".no_en"}, mem_en, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk({tag, ".flag"}, misaligned, 1);
    chk({tag, ".exc"}, exc_addr, a);
    chk({tag, ".ready"}, req_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".pulse"}, misaligned, 0);
  endtask

  initial begin
    rst = 1; idle_inputs(); addr = 0; wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", stall, 0);
    chk("rst.en", mem_en, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.lv", load_valid, 0);
    chk("rst.mis", misaligned, 0);
    chk("rst.berr", bus_err, 0);
    chk("rst.ld", load_data, 0);
    chk("rst.exc", exc_addr, 0);
    chk("rst.ready", req_ready, 1);
    #1 rst = 0;

    do_store("sb103", 1, 32'h103, 32'h000000AB, 0);
    do_store("sh002", 2, 32'h2, 32'h1234CDEF, 0);
    do_store("sw_ld", 3, 32'h40, 32'hDEADBEEF, 1);

    do_load("lb",  0, 32'h2, 32'h00800000, 1);
    do_load("lbu", 3, 32'h2, 32'h00800000, 1);
    do_load("lh",  1, 32'h2, 32'h8001FFFF, 3);
    do_load("lhu", 4, 32'h2, 32'h8001FFFF, 3);
    do_load("lw",  2, 32'h10, 32'hCAFEF00D, 2);

    do_mis("sw6", 0, 0, 3, 32'h6);
    do_mis("lh1", 1, 1, 0, 32'h1);

    // Timeout: four WAIT cycles with no rvalid, then bus_err.
    @(posedge clk); #1;
    req_valid = 1; load = 1; mask = 3'd2; mem_write = 0; addr = 32'h0000_0A40;
    @(negedge clk);
    chk("to.en", mem_en, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      idle_inputs(); addr = 32'h5555_0000;
      @(negedge clk);
      chk("to.stall", stall, 1);
      chk("to.berr_early", bus_err, 0);
    end
    @(posedge clk); #1;
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("to.berr", bus_err, 1);
    chk("to.exc", exc_addr, 32'h0000_0A40);
    chk("to.ready", req_ready, 1);
    chk("to.stall_drop", stall, 0);
    chk("to.lv", load_valid, 0);
    @(posedge clk); #1;
    mem_rvalid = 0;
    @(negedge clk);
    chk("to.late_rvalid", load_valid, 0);
    chk("to.berr_pulse", bus_err, 0);
    chk("to.ld_kept", load_data, 32'hCAFEF00D);

    // Reset during the second WAIT cycle.
    @(posedge clk); #1;
    req_valid = 1; load = 1; mask = 3'd2; mem_write = 0; addr = 32'h80;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    chk("rw.stall", stall, 0);
    chk("rw.ready", req_ready, 1);
    chk("rw.lv", load_valid, 0);
    chk("rw.berr", bus_err, 0);
    chk("rw.exc", exc_addr, 0);
    chk("rw.ld", load_data, 0);
    @(posedge clk); #1;
    mem_rvalid = 0;
    @(negedge clk);
    chk("rw.stale", load_valid, 0);
    chk("rw.stall2", stall, 0);

    // Randomized mix; misalignment falls out of random addresses.
    for (int n = 0; n < 80; n++) begin
      int kind, m, mw;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = $urandom;
      if (kind == 0) begin
        mw = $urandom_range(1, 3);
        if (a % (1 << (mw - 1)) != 0) do_mis("r.st_mis", 1'($urandom_range(0, 1)), 0, mw, a);
        else do_store("r.st", mw, a, $urandom, 1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        m = $urandom_range(0, 4);
        if (a % ld_bytes(m) != 0) do_mis("r.ld_mis", 1, m, 0, a);
        else do_load("r.ld", m, a, $urandom, $urandom_range(1, 3));
      end else begin
        m = $urandom_range(5, 7);
        @(posedge clk); #1;
        req_valid = 1; load = 1; mask = 3'(m); mem_write = 0; addr = a;
        @(negedge clk);
        chk("r.bad_en", mem_en, 0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("r.bad_mis", misaligned, 0);
        chk("r.bad_ready", req_ready, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
